avmm_switch_led_pio: RTL and testbench
======================================

Name: avmm_switch_led_pio

Overview:
- Avalon-MM slave peripheral that the Nios II data master uses to read the board slide switches and drive the red LEDs.
- Sits inside the Nios system and is exported as two conduits: switches in, LEDs out.
- Adds switch synchronisation and debounce, rising-edge capture with a maskable interrupt, and atomic LED set/clear registers.

Parameters:
- WIDTH, 16, number of switch inputs and LED outputs (1..32).
- DEBOUNCE_CYCLES, 50000, clock cycles between switch samples (1 ms at 50 MHz); minimum 2.
- LED_RESET, 0, reset value of the LED register.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- avs_address  in  3  word address.
- avs_read  in  1  read strobe, single cycle.
- avs_write  in  1  write strobe, single cycle.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, valid one cycle after avs_read.
- irq  out  1  level interrupt to the CPU, active-high.
- sw_in  in  WIDTH  raw switch pins, asynchronous to clk.
- led_out  out  WIDTH  LED drive, registered.

Behaviour:
- Reset (asynchronous assert, synchronous release by design):
  - sync flops, samples, debounced value, edge_capture, irq_mask, avs_readdata, tick counter = 0
  - led_out = LED_RESET; irq = 0.
- Input path:
  - Two-flop synchroniser on sw_in.
  - A free-running counter counts 0..DEBOUNCE_CYCLES-1 and pulses tick when it wraps.
  - On tick: sample <= sync output; debounced <= sample only for bits where the new synced value equals the previous sample.
  - A bit must therefore be stable for two consecutive ticks before it changes.
- Edge capture:
  - A per-bit 0->1 transition of debounced sets the corresponding edge_capture bit.
  - Bits stay set until software clears them.
- Interrupt: irq = OR(edge_capture & irq_mask), registered, so it asserts one cycle after the capture or mask change.
- Register map (word addresses; bits above WIDTH read 0 and ignore writes):
  - 0 DATA: read-only, returns debounced.
  - 1 LED: read/write, the full LED register.
  - 2 LED_SET: write-only; LED <= LED | wdata. Reads 0.
  - 3 LED_CLR: write-only; LED <= LED & ~wdata. Reads 0.
  - 4 IRQ_MASK: read/write.
  - 5 EDGE: read returns edge_capture; write-1-to-clear.
  - 6, 7: reads return 0, writes are ignored.
- Bus timing:
  - No waitrequest; writes take effect at the clock edge where avs_write = 1.
  - Read data is registered and presented the cycle after avs_read.
  - avs_readdata holds its value until the next read.
  - avs_read and avs_write asserted together: the write executes, and the read returns pre-write data.
- Boundary cases:
  - A new edge in the same cycle as a W1C of that bit: the set wins, and the bit remains 1.
  - A DATA read during a debounce update returns the pre-update value.
  - LED output changes one cycle after the write edge, with no glitch.
  - Reset mid-transaction discards any pending read data; readdata = 0.
  - The tick counter restarts from 0 on reset.

Test Plan:
- Reset values (DEBOUNCE_CYCLES=4, LED_RESET=16'h00A5): assert reset for 3 cycles -> led_out = 16'h00A5, irq = 0, read of address 0 returns 0.
- LED atomics: write 1 = 16'h0F0F, write 2 = 16'h00F0, write 3 = 16'h000F -> read 1 returns 16'h0FF0 and led_out = 16'h0FF0, each update one cycle after its write.
- Debounce: sw_in bit 3 pulses high for 3 cycles -> DATA stays 0. Bit 3 held high for 3 ticks -> DATA = 16'h0008, first visible within 2 ticks + 2 sync cycles.
- Interrupt:
  - Write mask = 16'h0008, then raise debounced bit 3 -> EDGE = 16'h0008 and irq = 1.
  - Write 5 = 16'h0008 -> EDGE = 0 and irq = 0 next cycle.
  - An edge on bit 4 with mask bit 4 = 0 -> EDGE bit 4 = 1 and irq stays 0.
- Clear/set collision: issue a W1C of bit 3 in the exact cycle debounced bit 3 rises -> EDGE bit 3 = 1 and irq remains 1.
- Unmapped and mid-op reset:
  - Read addresses 6 and 7 -> 0.
  - Assert reset the cycle after avs_read of address 1 -> avs_readdata = 0 and led_out = LED_RESET.

Source files
------------

// File: rtl/avmm_switch_led_pio.sv
// Avalon-MM switch/LED PIO: debounced switch input with rising-edge capture and IRQ, plus LED register with set/clear aliases.
// Latency: writes take effect at the write edge, read data is registered one cycle after avs_read, irq is registered.
// Backpressure: none (no waitrequest); every access completes in a single cycle.
module avmm_switch_led_pio #(
    parameter int          WIDTH           = 16,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter logic [31:0] LED_RESET       = 32'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] led_out
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_LED  = 3'd1;
    localparam logic [2:0] ADDR_SET  = 3'd2;
    localparam logic [2:0] ADDR_CLR  = 3'd3;
    localparam logic [2:0] ADDR_MASK = 3'd4;
    localparam logic [2:0] ADDR_EDGE = 3'd5;

    logic [WIDTH-1:0] sync1, sync2;
    logic [WIDTH-1:0] sample, debounced, deb_next;
    logic [WIDTH-1:0] edge_capture, edge_next;
    logic [WIDTH-1:0] irq_mask, led_next;
    logic [WIDTH-1:0] wdata, stable, rise;
    logic [CW-1:0]    cnt;
    logic             tick;
    logic [31:0]      rd_mux;

    assign wdata   = avs_writedata[WIDTH-1:0];
    assign tick    = (cnt == CNT_MAX);
    assign stable  = ~(sync2 ^ sample);
    assign rise    = deb_next & ~debounced;

    // A debounced bit follows the synced input only when two consecutive tick samples agree.
    always_comb begin
        deb_next = debounced;
        if (tick) begin
            deb_next = (debounced & ~stable) | (sync2 & stable);
        end
    end

    // LED register update; set/clear aliases give atomic bit manipulation.
    always_comb begin
        led_next = led_out;
        if (avs_write) begin
            case (avs_address)
                ADDR_LED: led_next = wdata;
                ADDR_SET: led_next = led_out | wdata;
                ADDR_CLR: led_next = led_out & ~wdata;
                default:  led_next = led_out;
            endcase
        end
    end

    // Edge capture: write-1-to-clear, but a new rising edge in the same cycle wins.
    always_comb begin
        edge_next = edge_capture;
        if (avs_write && avs_address == ADDR_EDGE) begin
            edge_next = edge_capture & ~wdata;
        end
        edge_next = edge_next | rise;
    end

    // Read mux over pre-write register state; unmapped and write-only words read 0.
    always_comb begin
        rd_mux = 32'h0;
        case (avs_address)
            ADDR_DATA: rd_mux = 32'(debounced);
            ADDR_LED:  rd_mux = 32'(led_out);
            ADDR_MASK: rd_mux = 32'(irq_mask);
            ADDR_EDGE: rd_mux = 32'(edge_capture);
            default:   rd_mux = 32'h0;
        endcase
    end

    // Input path: two-flop synchroniser, sample tick counter and debounce registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            sample    <= '0;
            debounced <= '0;
            cnt       <= '0;
        end else begin
            sync1     <= sw_in;
            sync2     <= sync1;
            cnt       <= tick ? '0 : cnt + CW'(1);
            debounced <= deb_next;
            if (tick) begin
                sample <= sync2;
            end
        end
    end

    // Bus-visible registers, registered interrupt and held read data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_capture <= '0;
            irq_mask     <= '0;
            led_out      <= LED_RESET[WIDTH-1:0];
            irq          <= 1'b0;
            avs_readdata <= 32'h0;
        end else begin
            edge_capture <= edge_next;
            led_out      <= led_next;
            irq          <= |(edge_capture & irq_mask);
            if (avs_write && avs_address == ADDR_MASK) begin
                irq_mask <= wdata;
            end
            if (avs_read) begin
                avs_readdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_avmm_switch_led_pio.sv
// Testbench for avmm_switch_led_pio: directed steps plus a randomized phase against a cycle-level reference model.
// Latency: inputs change on falling edges, outputs are compared on falling edges.
// Backpressure: not applicable (the slave has no waitrequest).
module tb_avmm_switch_led_pio;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        irq;
    logic [15:0] sw_in = '0;
    logic [15:0] led_out;

    int n_cmp = 0;
    int n_bad = 0;

    avmm_switch_led_pio #(
        .WIDTH(16),
        .DEBOUNCE_CYCLES(4),
        .LED_RESET(32'h0000_00A5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .avs_address(avs_address),
        .avs_read(avs_read),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata),
        .irq(irq),
        .sw_in(sw_in),
        .led_out(led_out)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [15:0] m_led, m_mask, m_edge, m_deb, m_samp;
    logic        m_irq;
    logic [31:0] m_rd;
    int          m_k;
    logic [15:0] swq[$];

    function automatic logic [31:0] model_read(input logic [2:0] a);
        case (a)
            3'd0:    return {16'h0, m_deb};
            3'd1:    return {16'h0, m_led};
            3'd4:    return {16'h0, m_mask};
            3'd5:    return {16'h0, m_edge};
            default: return 32'h0;
        endcase
    endfunction

    // True when debounced bit b would rise at the coming clock edge.
    function automatic bit rise_next(input int b);
        logic [15:0] s;
        s = swq[0];
        return ((m_k % 4) == 3) && s[b] && m_samp[b] && !m_deb[b];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_led = 16'h00A5; m_mask = '0; m_edge = '0; m_deb = '0; m_samp = '0;
            m_irq = 1'b0; m_rd = '0; m_k = 0;
            swq = {16'h0, 16'h0};
        end else begin
            logic [15:0] synced, w, nd;
            logic [15:0] old_edge, old_mask;
            bit          tk;
            old_edge = m_edge;
            old_mask = m_mask;
            synced = swq.pop_front();
            swq.push_back(sw_in);
            tk = (m_k % 4) == 3;
            m_k++;
            if (avs_read) m_rd = model_read(avs_address);
            w = avs_writedata[15:0];
            if (avs_write) begin
                case (avs_address)
                    3'd1: m_led = w;
                    3'd2: m_led = m_led | w;
                    3'd3: m_led = m_led & ~w;
                    3'd4: m_mask = w;
                    3'd5: m_edge = m_edge & ~w;
                    default: ;
                endcase
            end
            nd = m_deb;
            if (tk) begin
                for (int b = 0; b < 16; b++)
                    if (synced[b] == m_samp[b]) nd[b] = synced[b];
                m_samp = synced;
            end
            m_edge = m_edge | (nd & ~m_deb);
            m_deb = nd;
            m_irq = |(old_edge & old_mask);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    initial begin
        logic [31:0] rd;
        bit          found;

        // Reset values
        cyc(3);
        reset = 1'b0;
        chk("reset_led", {16'h0, led_out}, 32'h00A5);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        bus_read(3'd0, rd);
        chk("reset_data", rd, 32'h0);

        // LED atomics, each visible one cycle after its write
        bus_write(3'd1, 32'h0F0F); chk("led_wr", {16'h0, led_out}, 32'h0F0F);
        bus_write(3'd2, 32'h00F0); chk("led_set", {16'h0, led_out}, 32'h0FFF);
        bus_write(3'd3, 32'h000F); chk("led_clr", {16'h0, led_out}, 32'h0FF0);
        bus_read(3'd1, rd);
        chk("led_read", rd, 32'h0FF0);
        chk("led_model", {16'h0, led_out}, {16'h0, m_led});

        // Debounce: a 3-cycle glitch never reaches DATA
        sw_in = 16'h0008; cyc(3); sw_in = 16'h0000;
        for (int i = 0; i < 12; i++) begin
            bus_read(3'd0, rd);
            chk("glitch_data", rd, 32'h0);
        end

        // Held input becomes visible within two ticks plus synchroniser delay
        sw_in = 16'h0008; cyc(10);
        bus_read(3'd0, rd);
        chk("held_data", rd, 32'h0008);

        // Return to a clean state before the interrupt steps
        sw_in = 16'h0000; cyc(12);
        bus_write(3'd5, 32'hFFFF);
        bus_read(3'd5, rd);
        chk("edge_clean", rd, 32'h0);

        // Masked rising edge raises irq
        bus_write(3'd4, 32'h0008);
        sw_in = 16'h0008; cyc(12);
        bus_read(3'd5, rd);
        chk("edge_bit3", rd, 32'h0008);
        chk("irq_set", {31'h0, irq}, 32'h1);

        // W1C clears EDGE, irq drops the cycle after
        bus_write(3'd5, 32'h0008);
        cyc(1);
        chk("irq_clr", {31'h0, irq}, 32'h0);
        bus_read(3'd5, rd);
        chk("edge_clr", rd, 32'h0);

        // Unmasked edge is captured but does not interrupt
        sw_in = 16'h0018; cyc(12);
        bus_read(3'd5, rd);
        chk("edge_bit4", rd, 32'h0010);
        chk("irq_unmasked", {31'h0, irq}, 32'h0);

        // Clear/set collision on bit 3
        sw_in = 16'h0010; cyc(12);
        bus_write(3'd5, 32'hFFFF);
        sw_in = 16'h0018;
        found = 0;
        for (int i = 0; i < 24 && !found; i++) begin
            if (rise_next(3)) begin
                bus_write(3'd5, 32'h0008);
                found = 1;
            end else begin
                cyc(1);
            end
        end
        chk("collision_found", {31'h0, found}, 32'h1);
        cyc(1);
        chk("collision_irq", {31'h0, irq}, 32'h1);
        bus_read(3'd5, rd);
        chk("collision_edge", rd, 32'h0008);

        // Unmapped addresses
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_write(3'd7, 32'hFFFF_FFFF);
        bus_read(3'd6, rd); chk("unmapped6", rd, 32'h0);
        bus_read(3'd7, rd); chk("unmapped7", rd, 32'h0);
        bus_read(3'd2, rd); chk("set_reads0", rd, 32'h0);

        // Reset right after a read discards the read data
        bus_read(3'd1, rd);
        chk("preresete_rd", rd, m_rd);
        reset = 1'b1;
        #1;
        chk("midreset_rd", avs_readdata, 32'h0);
        chk("midreset_led", {16'h0, led_out}, 32'h00A5);
        @(negedge clk);
        cyc(1);
        reset = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            avs_address   = 3'($urandom_range(7));
            avs_read      = 1'($urandom_range(1));
            avs_write     = ($urandom_range(3) == 0);
            avs_writedata = $urandom;
            if ($urandom_range(7) == 0) sw_in = 16'($urandom);
            @(negedge clk);
            chk("rnd_led", {16'h0, led_out}, {16'h0, m_led});
            chk("rnd_irq", {31'h0, irq}, {31'h0, m_irq});
            chk("rnd_rd", avs_readdata, m_rd);
        end
        avs_read = 1'b0;
        avs_write = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
